pipe_stage_buf: RTL and testbench

- Parametrised elastic pipeline buffer register; the generic successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers.
- Carries one packed stage payload of WIDTH bits with a valid/ready handshake, a synchronous flush (bubble insertion) and an optional 2-entry skid.
- Each core stage boundary instantiates one copy, with the stage struct cast to the payload vector.

---
 rtl/pipe_stage_pkg.sv | 44 ++++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_stage_buf.sv | 93 +++++++++
 tb/tb_pipe_stage_buf.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared types and helpers for the core's stage-boundary buffers.
// Stage structs are cast to a flat vector when handed to pipe_stage_buf.
package pipe_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic valid;
    logic ready;
  } stage_hs_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        reg_we;
  } id_ex_t;

  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.pc    = '0;
    b.instr = NOP_INSTR;
    return b;
  endfunction

  function automatic id_ex_t id_ex_bubble();
    id_ex_t b;
    b.pc     = '0;
    b.instr  = NOP_INSTR;
    b.rd     = '0;
    b.reg_we = 1'b0;
    return b;
  endfunction

  function automatic logic [1:0] count_valid(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic stage-boundary buffer: valid/ready handshake, flush to bubble,
// optional skid entry (DEPTH=2) and a saturating backpressure counter.
module pipe_stage_buf
  import pipe_stage_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  if (DEPTH != 1 && DEPTH != 2) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH must be 1 or 2");
  end

  localparam bit HAS_SKID = (DEPTH == 2);

  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;
  stage_hs_t        in_hs, out_hs;
  logic             push, pop;

  if (HAS_SKID) begin : g_ready_skid
    assign in_ready = !skid_valid;
  end else begin : g_ready_pass
    // NOTE: without a skid entry, ready must pass out_ready through
    // combinationally or a full buffer could never refill while draining.
    assign in_ready = !main_valid || out_ready;
  end

  assign in_hs  = '{valid: in_valid,   ready: in_ready};
  assign out_hs = '{valid: main_valid, ready: out_ready};
  assign push   = in_hs.valid  & in_hs.ready;
  assign pop    = out_hs.valid & out_hs.ready;

  // Data registers reload BUBBLE whenever their entry empties, so out_data
  // needs no output mux and in_data is only captured on push.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid <= 1'b0;
      main_data  <= BUBBLE;
      skid_valid <= 1'b0;
      skid_data  <= BUBBLE;
    end else if (pop) begin
      if (skid_valid) begin
        main_data <= skid_data;
        if (push) begin
          skid_data <= in_data;
        end else begin
          skid_valid <= 1'b0;
          skid_data  <= BUBBLE;
        end
      end else if (push) begin
        main_data <= in_data;
      end else begin
        main_valid <= 1'b0;
        main_data  <= BUBBLE;
      end
    end else if (push) begin
      if (!main_valid) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else if (HAS_SKID) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = count_valid(main_valid, skid_valid);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .en    (main_valid & !out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives a DEPTH=2 (4-bit counter) and a DEPTH=1 buffer with shared stimulus
// and compares both against queue-based reference models.
module tb_pipe_stage_buf;

  localparam logic [31:0] BUB = 32'h13;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        d2_in_ready, d2_out_valid;
  logic [31:0] d2_out_data;
  logic [1:0]  d2_occ;
  logic [3:0]  d2_stall;

  logic        d1_in_ready, d1_out_valid;
  logic [31:0] d1_out_data;
  logic [1:0]  d1_occ;
  logic [15:0] d1_stall;

  int checks = 0;
  int errors = 0;

  logic [31:0] q2[$];
  logic [31:0] q1[$];
  int st2 = 0;
  int st1 = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .BUBBLE(BUB), .CNT_W(4)) u_d2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
    .occupancy(d2_occ), .stall_cnt(d2_stall)
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(1), .BUBBLE(BUB), .CNT_W(16)) u_d1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(d1_in_ready), .in_data(in_data),
    .out_valid(d1_out_valid), .out_ready(out_ready), .out_data(d1_out_data),
    .occupancy(d1_occ), .stall_cnt(d1_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check both DUTs against the models, then
  // advance the models across the clock edge.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] d, input logic ordy);
    logic rdy2, rdy1;
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    rdy2 = (q2.size() < 2);
    rdy1 = (q1.size() == 0) || ordy;

    check("d2.out_valid", {31'b0, d2_out_valid}, {31'b0, q2.size() != 0});
    check("d2.out_data",  d2_out_data, (q2.size() != 0) ? q2[0] : BUB);
    check("d2.occupancy", {30'b0, d2_occ}, q2.size());
    check("d2.in_ready",  {31'b0, d2_in_ready}, {31'b0, rdy2});
    check("d2.stall_cnt", {28'b0, d2_stall}, st2);
    check("d1.out_valid", {31'b0, d1_out_valid}, {31'b0, q1.size() != 0});
    check("d1.out_data",  d1_out_data, (q1.size() != 0) ? q1[0] : BUB);
    check("d1.occupancy", {30'b0, d1_occ}, q1.size());
    check("d1.in_ready",  {31'b0, d1_in_ready}, {31'b0, rdy1});
    check("d1.stall_cnt", {16'b0, d1_stall}, st1);

    @(posedge clk);
    if (rst) begin
      q2.delete(); q1.delete(); st2 = 0; st1 = 0;
    end else begin
      if (q2.size() != 0 && !ordy && st2 < 15)    st2++;
      if (q1.size() != 0 && !ordy && st1 < 65535) st1++;
      if (fl) begin
        q2.delete(); q1.delete();
      end else begin
        if (q2.size() != 0 && ordy) void'(q2.pop_front());
        if (q1.size() != 0 && ordy) void'(q1.pop_front());
        if (iv && rdy2) q2.push_back(d);
        if (iv && rdy1) q1.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held a second cycle, then observe the reset state.
    cycle(1, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // Streaming at full throughput.
    cycle(0, 0, 1, 32'hA1, 1);
    cycle(0, 0, 1, 32'hA2, 1);
    cycle(0, 0, 1, 32'hA3, 1);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // Backpressure: fill, attempt an extra push, then drain.
    cycle(0, 0, 1, 32'hB1, 0);
    cycle(0, 0, 1, 32'hB2, 0);
    cycle(0, 0, 1, 32'hB3, 0);
    cycle(0, 0, 0, 32'h0, 0);
    cycle(0, 0, 0, 32'h0, 0);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // Flush with a simultaneous push while full.
    cycle(0, 0, 1, 32'hC1, 0);
    cycle(0, 0, 1, 32'hC2, 0);
    cycle(0, 1, 1, 32'hC3, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // Stall counter saturation on the 4-bit instance.
    cycle(1, 0, 0, 32'h0, 1);
    cycle(0, 0, 1, 32'hE1, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 32'h0, 0);

    // Same-cycle replace through the DEPTH=1 pass-through ready.
    cycle(1, 0, 0, 32'h0, 1);
    cycle(0, 0, 1, 32'hD1, 0);
    cycle(0, 0, 1, 32'hD2, 1);
    cycle(0, 0, 0, 32'h0, 0);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 97) == 0, ($urandom % 19) == 0, ($urandom % 4) != 0,
            $urandom, ($urandom % 3) != 0);
    end
    cycle(0, 0, 0, 32'h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
